// File: rtl/vec_seq_pkg.sv
// Shared state encoding and sizing helpers for the vector lane sequencer.
package vec_seq_pkg;

    localparam int VEC_DATA_W = 128;
    localparam int VEC_LANE_W = 32;
    localparam int VEC_CTRL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int lane_count(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // Keep the index at least one bit wide even for a single-lane build.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vector_lane_sequencer.sv
// Issues a wide ALU operation one lane per cycle through a shared external lane ALU,
// stalling the pipeline until the assembled result and Zero flag are ready.
module vector_lane_sequencer
    import vec_seq_pkg::*;
#(
    parameter int DATA_W = VEC_DATA_W,
    parameter int LANE_W = VEC_LANE_W,
    parameter int CTRL_W = VEC_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              vectorial_i,
    input  logic [CTRL_W-1:0] alu_ctrl_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              flush_i,
    output logic [LANE_W-1:0] lane_a_o,
    output logic [LANE_W-1:0] lane_b_o,
    output logic [CTRL_W-1:0] lane_ctrl_o,
    output logic              lane_valid_o,
    input  logic [LANE_W-1:0] lane_result_i,
    input  logic              lane_zero_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    localparam int LANES = lane_count(DATA_W, LANE_W);
    localparam int IDX_W = lane_idx_w(LANES);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] src_a_q, src_a_d;
    logic [DATA_W-1:0] src_b_q, src_b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              vec_q, vec_d;
    logic              zero_q, zero_d;
    logic              accept;
    logic              last_lane;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        result_d     = result_q;
        ctrl_d       = ctrl_q;
        vec_d        = vec_q;
        zero_d       = zero_q;
        lane_a_o     = '0;
        lane_b_o     = '0;
        lane_valid_o = 1'b0;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        accept       = 1'b0;
        // A scalar op only ever visits lane 0, so it is always on its last lane.
        last_lane    = vec_q ? (idx_q == IDX_W'(LANES - 1)) : 1'b1;

        case (state_q)
            ST_IDLE: begin
                accept  = start_i & ~flush_i;
                stall_o = start_i & ~flush_i;
            end
            ST_ISSUE: begin
                lane_valid_o = 1'b1;
                stall_o      = 1'b1;
                lane_a_o     = src_a_q[int'(idx_q)*LANE_W +: LANE_W];
                lane_b_o     = src_b_q[int'(idx_q)*LANE_W +: LANE_W];
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d[int'(idx_q)*LANE_W +: LANE_W] = lane_result_i;
                    zero_d = zero_q & lane_zero_i;
                    if (last_lane) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done_o  = ~flush_i;
                stall_o = start_i;
                accept  = start_i & ~flush_i;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clearing the result keeps scalar upper lanes at zero; zero starts at the AND identity.
        if (accept) begin
            state_d  = ST_ISSUE;
            idx_d    = '0;
            src_a_d  = src_a_i;
            src_b_d  = src_b_i;
            ctrl_d   = alu_ctrl_i;
            vec_d    = vectorial_i;
            result_d = '0;
            zero_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            result_q <= '0;
            ctrl_q   <= '0;
            vec_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            result_q <= result_d;
            ctrl_q   <= ctrl_d;
            vec_q    <= vec_d;
            zero_q   <= zero_d;
        end
    end

    assign lane_ctrl_o = ctrl_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Randomized scoreboard bench for vector_lane_sequencer with an add/sub lane ALU
// standing in for the shared external ALU.
module tb_vector_lane_sequencer;

    localparam int DATA_W = 128;
    localparam int LANE_W = 32;
    localparam int CTRL_W = 3;
    localparam int LANES  = DATA_W / LANE_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i;
    logic              vectorial_i;
    logic [CTRL_W-1:0] alu_ctrl_i;
    logic [DATA_W-1:0] src_a_i;
    logic [DATA_W-1:0] src_b_i;
    logic              flush_i;
    logic [LANE_W-1:0] lane_a_o;
    logic [LANE_W-1:0] lane_b_o;
    logic [CTRL_W-1:0] lane_ctrl_o;
    logic              lane_valid_o;
    logic [LANE_W-1:0] lane_result;
    logic              lane_zero;
    logic              stall_o;
    logic              done_o;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;

    typedef struct {
        logic [DATA_W-1:0] res;
        logic              zero;
        int                due;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    bit   done_due   = 1'b0;

    vector_lane_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .vectorial_i  (vectorial_i),
        .alu_ctrl_i   (alu_ctrl_i),
        .src_a_i      (src_a_i),
        .src_b_i      (src_b_i),
        .flush_i      (flush_i),
        .lane_a_o     (lane_a_o),
        .lane_b_o     (lane_b_o),
        .lane_ctrl_o  (lane_ctrl_o),
        .lane_valid_o (lane_valid_o),
        .lane_result_i(lane_result),
        .lane_zero_i  (lane_zero),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .zero_o       (zero_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External lane ALU: ctrl 001 subtracts, anything else adds.
    always_comb begin
        lane_result = (lane_ctrl_o == 3'd1) ? lane_a_o - lane_b_o : lane_a_o + lane_b_o;
        lane_zero   = (lane_result == 32'd0);
    end

    task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: each active lane is an independent 32-bit add/sub, Zero is the AND over active lanes.
    function automatic void ref_model(input logic vec, input logic [CTRL_W-1:0] ctrl,
                                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                      output logic [DATA_W-1:0] res, output logic z);
        int n;
        logic [LANE_W-1:0] x, y, r;
        n   = vec ? LANES : 1;
        res = '0;
        z   = 1'b1;
        for (int i = 0; i < n; i++) begin
            x = a[i*LANE_W +: LANE_W];
            y = b[i*LANE_W +: LANE_W];
            r = (ctrl == 3'd1) ? x - y : x + y;
            res[i*LANE_W +: LANE_W] = r;
            if (r != 32'd0) z = 1'b0;
        end
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && done_o) begin
            if (exp_q.size() == 0) begin
                check_output("done_without_op", done_o, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_output("result", result_o, e.res);
                check_output("zero", zero_o, e.zero);
                check_output("done_cycle", cyc, e.due);
            end
        end
    end

    // Issue one op starting this cycle; flush_lane >= 0 aborts it during that lane.
    task automatic apply_stimulus(input logic vec, input logic [CTRL_W-1:0] ctrl,
                                  input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                  input int flush_lane);
        logic [DATA_W-1:0] r;
        logic z;
        int n;
        exp_t e;
        n           = vec ? LANES : 1;
        start_i     = 1'b1;
        flush_i     = 1'b0;
        vectorial_i = vec;
        alu_ctrl_i  = ctrl;
        src_a_i     = a;
        src_b_i     = b;
        @(negedge clk);
        check_output("done_pulse", done_o, done_due);
        done_due = 1'b0;
        check_output("stall_accept", stall_o, 1'b1);
        if (flush_lane < 0) begin
            ref_model(vec, ctrl, a, b, r, z);
            e.res  = r;
            e.zero = z;
            e.due  = cyc + n + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        src_a_i     = rand128();
        src_b_i     = rand128();
        alu_ctrl_i  = CTRL_W'($urandom);
        vectorial_i = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            if (i == flush_lane) flush_i = 1'b1;
            @(negedge clk);
            check_output("lane_valid", lane_valid_o, 1'b1);
            check_output("lane_a", lane_a_o, a[i*LANE_W +: LANE_W]);
            check_output("lane_b", lane_b_o, b[i*LANE_W +: LANE_W]);
            check_output("lane_ctrl", lane_ctrl_o, ctrl);
            check_output("stall_issue", stall_o, 1'b1);
            check_output("done_early", done_o, 1'b0);
            @(posedge clk);
            #1;
            if (i == flush_lane) begin
                flush_i = 1'b0;
                return;
            end
        end
        done_due = 1'b1;
    endtask

    task automatic idle_cycle();
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        check_output("done_pulse", done_o, done_due);
        done_due = 1'b0;
        check_output("stall_idle", stall_o, 1'b0);
        check_output("lane_valid_idle", lane_valid_o, 1'b0);
        check_output("lane_a_idle", lane_a_o, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_result"}, result_o, '0);
        check_output({tag, "_zero"}, zero_o, 1'b0);
        check_output({tag, "_done"}, done_o, 1'b0);
        check_output({tag, "_stall"}, stall_o, 1'b0);
        check_output({tag, "_valid"}, lane_valid_o, 1'b0);
        check_output({tag, "_ctrl"}, lane_ctrl_o, '0);
        check_output({tag, "_lane_a"}, lane_a_o, '0);
    endtask

    initial begin
        logic [DATA_W-1:0] a, b;
        logic              vec;
        logic [CTRL_W-1:0] ctrl;
        int                fl;

        start_i     = 1'b0;
        flush_i     = 1'b0;
        vectorial_i = 1'b0;
        alu_ctrl_i  = '0;
        src_a_i     = '0;
        src_b_i     = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle();

        $display("[TB] directed vector add");
        a = {32'd4, 32'd3, 32'd2, 32'd1};
        b = {32'd40, 32'd30, 32'd20, 32'd10};
        apply_stimulus(1'b1, 3'd0, a, b, -1);
        idle_cycle();
        check_output("vadd_held", result_o, 128'h0000002C_00000021_00000016_0000000B);
        check_output("vadd_zero", zero_o, 1'b0);

        $display("[TB] directed scalar sub");
        a = {rand128()} ^ 128'h0;
        a[31:0] = 32'd5;
        b = rand128();
        b[31:0] = 32'd5;
        apply_stimulus(1'b0, 3'd1, a, b, -1);
        idle_cycle();
        check_output("ssub_held", result_o, '0);
        check_output("ssub_zero", zero_o, 1'b1);

        $display("[TB] vector sub zero flag");
        a = rand128();
        b = a;
        b[95:64] = b[95:64] + 32'd1;
        apply_stimulus(1'b1, 3'd1, a, b, -1);
        idle_cycle();
        check_output("vsub_lane2_zero", zero_o, 1'b0);
        apply_stimulus(1'b1, 3'd1, a, a, -1);
        idle_cycle();
        check_output("vsub_equal_zero", zero_o, 1'b1);

        $display("[TB] back-to-back");
        apply_stimulus(1'b1, 3'd0, rand128(), rand128(), -1);
        apply_stimulus(1'b1, 3'd1, rand128(), rand128(), -1);
        apply_stimulus(1'b0, 3'd0, rand128(), rand128(), -1);
        idle_cycle();

        $display("[TB] flush and start+flush");
        apply_stimulus(1'b1, 3'd0, rand128(), rand128(), 2);
        idle_cycle();
        start_i     = 1'b1;
        flush_i     = 1'b1;
        vectorial_i = 1'b1;
        @(negedge clk);
        check_output("start_flush_stall", stall_o, 1'b0);
        @(posedge clk);
        #1;
        idle_cycle();

        $display("[TB] async reset mid-issue");
        start_i     = 1'b1;
        vectorial_i = 1'b1;
        alu_ctrl_i  = 3'd1;
        src_a_i     = {4{32'h1234_5678}};
        src_b_i     = {4{32'h0000_0001}};
        @(posedge clk);
        #1 start_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle();
        apply_stimulus(1'b1, 3'd0, rand128(), rand128(), -1);
        idle_cycle();

        $display("[TB] randomized ops");
        for (int k = 0; k < 60; k++) begin
            vec  = 1'($urandom);
            ctrl = CTRL_W'($urandom_range(0, 1));
            a    = rand128();
            b    = ($urandom_range(0, 3) == 0) ? a : rand128();
            fl   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, vec ? LANES - 1 : 0) : -1;
            apply_stimulus(vec, ctrl, a, b, fl);
            if (fl >= 0 || $urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        check_output("pending_ops", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
